tmds_mode_switcher: RTL and testbench



---
 rtl/tmds_mode_switcher_pkg.sv | 28 ++
 rtl/tmds_mode_switcher_if.sv | 45 ++++
 rtl/tmds_mode_switcher_sync.sv | 31 +++
 rtl/tmds_mode_switcher.sv | 148 ++++++++++++++
 tb/tb_tmds_mode_switcher.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/tmds_mode_switcher_pkg.sv
// -----------------------------------------------------------------------------
// tmds_switch_pkg
// Shared types and constants for the TMDS DVI/HDMI mode switcher.
//   state_e    : switcher FSM states (RUN, WAIT_ORIGIN, MUTE)
//   CTL_TOKEN  : TMDS control token sent on every lane while muted
//   CX_W/CY_W  : coordinate widths of the encoder cores
//   is_origin  : frame-origin detector on a coordinate pair
// -----------------------------------------------------------------------------
package tmds_switch_pkg;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    WAIT_ORIGIN = 2'd1,
    MUTE        = 2'd2
  } state_e;

  localparam int TMDS_W = 10;
  localparam int CX_W   = 12;
  localparam int CY_W   = 11;

  localparam logic [TMDS_W-1:0] CTL_TOKEN = 10'b1101010100;

  function automatic logic is_origin(input logic [CX_W-1:0] x,
                                     input logic [CY_W-1:0] y);
    return (x == '0) && (y == '0);
  endfunction

endpackage

// File: rtl/tmds_mode_switcher_if.sv
// -----------------------------------------------------------------------------
// tmds_mode_switcher_if
// Bundles the mode request, both encoder cores' symbols/coordinates and the
// switcher outputs.
//   slave  : the switcher (consumes core data, drives tmds_channels/cx/cy/status)
//   master : the surrounding video path (drives request and core data)
// Optional macro TMDS_SWITCH_COUNT_EN adds switch_count.
// -----------------------------------------------------------------------------
interface tmds_mode_switcher_if #(
  parameter int NUM_CHANNELS = 3
);

  logic                                   dvi_request;
  logic [NUM_CHANNELS-1:0][9:0]           tmds_hdmi;
  logic [NUM_CHANNELS-1:0][9:0]           tmds_dvi;
  logic [tmds_switch_pkg::CX_W-1:0]       cx_hdmi;
  logic [tmds_switch_pkg::CY_W-1:0]       cy_hdmi;
  logic [tmds_switch_pkg::CX_W-1:0]       cx_dvi;
  logic [tmds_switch_pkg::CY_W-1:0]       cy_dvi;
  logic [NUM_CHANNELS-1:0][9:0]           tmds_channels;
  logic [tmds_switch_pkg::CX_W-1:0]       cx;
  logic [tmds_switch_pkg::CY_W-1:0]       cy;
  logic                                   dvi_active;
  logic                                   switching;
`ifdef TMDS_SWITCH_COUNT_EN
  logic [15:0]                            switch_count;
`endif

  modport slave (
    input  dvi_request, tmds_hdmi, tmds_dvi, cx_hdmi, cy_hdmi, cx_dvi, cy_dvi,
`ifdef TMDS_SWITCH_COUNT_EN
    output switch_count,
`endif
    output tmds_channels, cx, cy, dvi_active, switching
  );

  modport master (
    output dvi_request, tmds_hdmi, tmds_dvi, cx_hdmi, cy_hdmi, cx_dvi, cy_dvi,
`ifdef TMDS_SWITCH_COUNT_EN
    input  switch_count,
`endif
    input  tmds_channels, cx, cy, dvi_active, switching
  );

endinterface

// File: rtl/tmds_mode_switcher_sync.sv
// -----------------------------------------------------------------------------
// bit_synchroniser
// STAGES-deep flip-flop chain bringing a single asynchronous bit into clk_i.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, loads every stage with RESET_VAL
//   d_i   : asynchronous input bit
//   q_o   : synchronised output (last stage)
// -----------------------------------------------------------------------------
module bit_synchroniser #(
  parameter int STAGES    = 2,
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/tmds_mode_switcher.sv
// -----------------------------------------------------------------------------
// tmds_mode_switcher
// Glitch-managed run-time selector between the HDMI and DVI TMDS encoder
// cores. A (possibly asynchronous) DVI request is synchronised, the switch is
// deferred to a frame origin of the active core, and the lanes are then held
// at the control token for MUTE_FRAMES frame origins so the sink re-locks.
//
// Ports:
//   clk_pixel : pixel clock, the only clock
//   reset     : synchronous active-high reset
//   bus       : tmds_mode_switcher_if.slave
//                 in : dvi_request, tmds_hdmi/tmds_dvi, cx/cy of both cores
//                 out: tmds_channels (registered, 1-cycle latency),
//                      cx/cy (active core, combinational), dvi_active,
//                      switching, switch_count (TMDS_SWITCH_COUNT_EN only)
//
// Optional feature macro: TMDS_SWITCH_COUNT_EN
//   Adds a saturating 16-bit count of completed mode changes.
// -----------------------------------------------------------------------------
module tmds_mode_switcher
  import tmds_switch_pkg::*;
#(
  parameter int NUM_CHANNELS = 3,
  parameter int MUTE_FRAMES  = 2,
  parameter int SYNC_STAGES  = 2,
  parameter bit DVI_AT_RESET = 1'b0
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  tmds_mode_switcher_if.slave  bus
);

  localparam logic [7:0] MUTE_LOAD = 8'(MUTE_FRAMES - 1);

  state_e                       state_q;
  logic                         dvi_active_q;
  logic [7:0]                   mute_cnt_q;
  logic                         origin_q;
  logic [NUM_CHANNELS-1:0][9:0] tmds_q;
  logic [NUM_CHANNELS-1:0][9:0] tmds_d;
  logic                         req_s;
  logic                         origin;
  logic                         frame_pulse;
  logic [CX_W-1:0]              cx_sel;
  logic [CY_W-1:0]              cy_sel;

`ifdef TMDS_SWITCH_COUNT_EN
  logic [15:0]                  switch_count_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  bit_synchroniser #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (DVI_AT_RESET)
  ) u_req_sync (
    .clk_i (clk_pixel),
    .rst_i (reset),
    .d_i   (bus.dvi_request),
    .q_o   (req_s)
  );

  // Coordinates follow the mode currently on the wire, so during a mute the
  // origin detector keeps tracking the core that is being switched away from.
  assign cx_sel = dvi_active_q ? bus.cx_dvi : bus.cx_hdmi;
  assign cy_sel = dvi_active_q ? bus.cy_dvi : bus.cy_hdmi;

  // Edge-detect the origin so a coordinate stalled at (0,0) counts once.
  assign origin      = is_origin(cx_sel, cy_sel);
  assign frame_pulse = origin && !origin_q;

  always_comb begin
    tmds_d = tmds_q;
    if (state_q == MUTE) begin
      tmds_d = {NUM_CHANNELS{CTL_TOKEN}};
    end else if (dvi_active_q) begin
      tmds_d = bus.tmds_dvi;
    end else begin
      tmds_d = bus.tmds_hdmi;
    end
  end

  // ---- output register stage / mode FSM ----
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state_q      <= RUN;
      dvi_active_q <= DVI_AT_RESET;
      mute_cnt_q   <= '0;
      origin_q     <= 1'b0;
      tmds_q       <= {NUM_CHANNELS{CTL_TOKEN}};
`ifdef TMDS_SWITCH_COUNT_EN
      switch_count_q <= '0;
`endif
    end else begin
      origin_q <= origin;
      tmds_q   <= tmds_d;
      case (state_q)
        RUN: begin
          // A coincident frame_pulse is deliberately not consumed here; the
          // mute is anchored to the next clean origin.
          if (req_s != dvi_active_q) begin
            state_q <= WAIT_ORIGIN;
          end
        end
        WAIT_ORIGIN: begin
          if (req_s == dvi_active_q) begin
            state_q <= RUN;
          end else if (frame_pulse) begin
            state_q    <= MUTE;
            mute_cnt_q <= MUTE_LOAD;
          end
        end
        MUTE: begin
          // Request reversals do not abort the mute; the mode taken at exit
          // is whatever the synchronised request is on the final origin.
          if (frame_pulse) begin
            if (mute_cnt_q == '0) begin
              dvi_active_q <= req_s;
              state_q      <= RUN;
`ifdef TMDS_SWITCH_COUNT_EN
              if (req_s != dvi_active_q) begin
                switch_count_q <= sat_inc16(switch_count_q);
              end
`endif
            end else begin
              mute_cnt_q <= mute_cnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign bus.tmds_channels = tmds_q;
  assign bus.cx            = cx_sel;
  assign bus.cy            = cy_sel;
  assign bus.dvi_active    = dvi_active_q;
  assign bus.switching     = (state_q != RUN);
`ifdef TMDS_SWITCH_COUNT_EN
  assign bus.switch_count  = switch_count_q;
`endif

endmodule

// File: tb/tb_tmds_mode_switcher.sv
// -----------------------------------------------------------------------------
// tb_tmds_mode_switcher
// Directed bench for tmds_mode_switcher with NUM_CHANNELS=3, MUTE_FRAMES=2,
// SYNC_STAGES=2, DVI_AT_RESET=0. Inputs change 1 ns after a rising edge and
// outputs are sampled at the same point, i.e. away from the active edge.
// -----------------------------------------------------------------------------
module tb_tmds_mode_switcher;

  localparam logic [29:0] CTL3 = {3{10'h354}};
  localparam logic [29:0] H0   = {10'h133, 10'h122, 10'h111};
  localparam logic [29:0] H2   = {10'h0F3, 10'h0E2, 10'h0D1};
  localparam logic [29:0] D0   = {10'h2CC, 10'h2BB, 10'h2AA};

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  tmds_mode_switcher_if #(.NUM_CHANNELS(3)) bus ();

  tmds_mode_switcher #(
    .NUM_CHANNELS (3),
    .MUTE_FRAMES  (2),
    .SYNC_STAGES  (2),
    .DVI_AT_RESET (1'b0)
  ) dut (
    .clk_pixel (clk),
    .reset     (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_xy(input int x, input int y);
    bus.cx_hdmi = 12'(x);
    bus.cx_dvi  = 12'(x);
    bus.cy_hdmi = 11'(y);
    bus.cy_dvi  = 11'(y);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset with request low
    rst             = 1'b1;
    bus.dvi_request = 1'b0;
    bus.tmds_hdmi   = H0;
    bus.tmds_dvi    = D0;
    set_xy(100, 200);
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_tmds",      64'(bus.tmds_channels), 64'(CTL3));
    chk("rst_dvi",       64'(bus.dvi_active),    64'd0);
    chk("rst_switching", 64'(bus.switching),     64'd0);
`ifdef TMDS_SWITCH_COUNT_EN
    chk("rst_count",     64'(bus.switch_count),  64'd0);
`endif
    tick();
    chk("run_hdmi", 64'(bus.tmds_channels), 64'(H0));
    bus.tmds_hdmi = H2;
    tick();
    chk("latency", 64'(bus.tmds_channels), 64'(H2));
    bus.cx_hdmi = 12'd7; bus.cx_dvi = 12'd9;
    bus.cy_hdmi = 11'd3; bus.cy_dvi = 11'd4;
    #1;
    chk("cx_hdmi_sel", 64'(bus.cx), 64'd7);
    chk("cy_hdmi_sel", 64'(bus.cy), 64'd3);
    set_xy(100, 200);

    // HDMI -> DVI with a two-origin mute
    bus.dvi_request = 1'b1;
    tick(); tick();
    chk("sync_lat", 64'(bus.switching), 64'd0);
    tick();
    chk("wait_enter", 64'(bus.switching), 64'd1);
    tick(); tick(); tick();
    chk("wait_tmds", 64'(bus.tmds_channels), 64'(H2));
    chk("wait_dvi",  64'(bus.dvi_active),    64'd0);
    set_xy(0, 0);
    tick();
    chk("mute_not_yet", 64'(bus.tmds_channels), 64'(H2));
    tick();
    chk("mute_ctl", 64'(bus.tmds_channels), 64'(CTL3));
    set_xy(1, 0);
    tick();
    set_xy(0, 0);
    tick();
    chk("mute_mid_sw",  64'(bus.switching),  64'd1);
    chk("mute_mid_dvi", 64'(bus.dvi_active), 64'd0);
    set_xy(5, 0);
    tick();
    set_xy(0, 0);
    tick();
    chk("exit_mode",     64'(bus.dvi_active),    64'd1);
    chk("exit_sw",       64'(bus.switching),     64'd0);
    chk("exit_last_ctl", 64'(bus.tmds_channels), 64'(CTL3));
    tick();
    chk("dvi_out", 64'(bus.tmds_channels), 64'(D0));
    bus.cx_hdmi = 12'd7; bus.cx_dvi = 12'd9;
    bus.cy_hdmi = 11'd3; bus.cy_dvi = 11'd4;
    #1;
    chk("cx_dvi_sel", 64'(bus.cx), 64'd9);
    chk("cy_dvi_sel", 64'(bus.cy), 64'd4);
    set_xy(100, 200);
`ifdef TMDS_SWITCH_COUNT_EN
    chk("count_one", 64'(bus.switch_count), 64'd1);
`endif

    // Request raised then withdrawn before any origin: no mute
    bus.dvi_request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_tmds_a", 64'(bus.tmds_channels), 64'(D0));
    end
    chk("wd_wait", 64'(bus.switching), 64'd1);
    bus.dvi_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_tmds_b", 64'(bus.tmds_channels), 64'(D0));
    end
    chk("wd_run", 64'(bus.switching),  64'd0);
    chk("wd_dvi", 64'(bus.dvi_active), 64'd1);

    // Reversal during MUTE plus a stalled origin
    bus.dvi_request = 1'b0;
    tick(); tick(); tick();
    chk("rev_wait", 64'(bus.switching), 64'd1);
    set_xy(0, 0);
    tick();
    set_xy(1, 0);
    bus.dvi_request = 1'b1;
    tick();
    set_xy(0, 0);
    for (int i = 0; i < 50; i++) tick();
    chk("stall_once", 64'(bus.switching),     64'd1);
    chk("stall_ctl",  64'(bus.tmds_channels), 64'(CTL3));
    set_xy(1, 0);
    tick();
    set_xy(0, 0);
    tick();
    chk("rev_mode", 64'(bus.dvi_active), 64'd1);
    chk("rev_exit", 64'(bus.switching),  64'd0);
    tick();
    chk("rev_tmds", 64'(bus.tmds_channels), 64'(D0));
`ifdef TMDS_SWITCH_COUNT_EN
    chk("cnt_nochg", 64'(bus.switch_count), 64'd1);
`endif

    // Request change coinciding with an origin while in RUN
    bus.dvi_request = 1'b0;
    set_xy(1, 0);
    tick(); tick();
    set_xy(0, 0);
    tick();
    chk("simul_wait", 64'(bus.switching), 64'd1);
    tick(); tick(); tick();
    chk("simul_no_mute", 64'(bus.tmds_channels), 64'(D0));
    set_xy(1, 0);
    tick();
    set_xy(0, 0);
    tick();
    tick();
    chk("simul_mute", 64'(bus.tmds_channels), 64'(CTL3));
    chk("simul_dvi",  64'(bus.dvi_active),    64'd1);

    // Reset in the middle of a mute
    rst = 1'b1;
    tick();
    chk("rst2_tmds", 64'(bus.tmds_channels), 64'(CTL3));
    chk("rst2_sw",   64'(bus.switching),     64'd0);
    chk("rst2_dvi",  64'(bus.dvi_active),    64'd0);
`ifdef TMDS_SWITCH_COUNT_EN
    chk("rst2_count", 64'(bus.switch_count), 64'd0);
`endif
    rst = 1'b0;
    set_xy(100, 200);
    bus.tmds_hdmi = H0;
    tick();
    chk("post_rst_tmds", 64'(bus.tmds_channels), 64'(H0));
    chk("post_rst_sw",   64'(bus.switching),     64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
